// File: rtl/cdb_writeback_pkg.sv
// Shared OoO pipeline definitions for result writeback: default widths, source-select
// encoding, result record and the writeback queue depth (selected by CDB_FIFO_EN).
package cdb_writeback_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 6;

  localparam logic SEL_ALU = 1'b0;
  localparam logic SEL_LS  = 1'b1;

  typedef struct packed {
    logic                  valid;
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] data;
  } cdb_result_t;

  // Two entries let a new result be captured while the previous one waits on the ROB;
  // a single entry costs one bubble between back-to-back results.
`ifdef CDB_FIFO_EN
  localparam int CDB_DEPTH = 2;
`else
  localparam int CDB_DEPTH = 1;
`endif

endpackage

// File: rtl/cdb_fifo.sv
// In-order result queue: storage, wrapping read/write pointers and occupancy counter.
// flush empties the queue and discards a same-cycle push.
module cdb_fifo
  import cdb_writeback_pkg::*;
#(
  parameter int DEPTH = CDB_DEPTH,
  parameter int W     = TAG_W_DEF + DATA_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MEM_N = 1 << PTR_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [MEM_N];
  logic [W-1:0]     mem_d [MEM_N];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_N; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);

endmodule

// File: rtl/cdb_writeback.sv
// Common data bus writeback stage: selects the granted ALU or load/store result, queues it
// and broadcasts the oldest entry. Queue depth is 2 with CDB_FIFO_EN defined, 1 otherwise.
module cdb_writeback
  import cdb_writeback_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ls_valid,
  input  logic [TAG_W-1:0]  ls_tag,
  input  logic [DATA_W-1:0] ls_data,
  input  logic              sel_result,
  input  logic              flush,
  input  logic              rob_ready,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              wb_stall
);

  localparam int W = TAG_W + DATA_W;

  logic              sel_valid;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;
  logic              push, pop;
  logic              q_empty, q_full;
  logic [W-1:0]      q_rd_data;

  always_comb begin
    sel_valid = alu_valid;
    sel_tag   = alu_tag;
    sel_data  = alu_data;
    if (sel_result == SEL_LS) begin
      sel_valid = ls_valid;
      sel_tag   = ls_tag;
      sel_data  = ls_data;
    end
  end

  // Stall comes straight from the registered occupancy, so the arbiter never sees a
  // combinational path from rob_ready.
  assign wb_stall  = q_full;
  assign cdb_valid = ~q_empty;
  assign push      = sel_valid & ~wb_stall & ~flush;
  assign pop       = cdb_valid & rob_ready;
  assign cdb_tag   = q_rd_data[DATA_W +: TAG_W];
  assign cdb_data  = q_rd_data[DATA_W-1:0];

  cdb_fifo #(
    .DEPTH (CDB_DEPTH),
    .W     (W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data ({sel_tag, sel_data}),
    .rd_data (q_rd_data),
    .empty   (q_empty),
    .full    (q_full)
  );

endmodule

// File: tb/tb_cdb_writeback.sv
// Self-checking bench for cdb_writeback: directed scenarios then random traffic, checked
// against a queue-based model of the writeback buffer (depth follows CDB_FIFO_EN).
module tb_cdb_writeback;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
`ifdef CDB_FIFO_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid, ls_valid, sel_result, flush, rob_ready;
  logic [TAG_W-1:0]  alu_tag, ls_tag;
  logic [DATA_W-1:0] alu_data, ls_data;
  logic              cdb_valid, wb_stall;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  int total = 0;
  int bad   = 0;

  logic [TAG_W+DATA_W-1:0] exp_q[$];
  bit                      fresh_reset = 1'b0;

  always #5 clk = ~clk;

  cdb_writeback #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_tag    (alu_tag),
    .alu_data   (alu_data),
    .ls_valid   (ls_valid),
    .ls_tag     (ls_tag),
    .ls_data    (ls_data),
    .sel_result (sel_result),
    .flush      (flush),
    .rob_ready  (rob_ready),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data),
    .wb_stall   (wb_stall)
  );

  task automatic check_outputs(input string tag);
    logic                    e_valid;
    logic                    e_stall;
    logic [TAG_W+DATA_W-1:0] head;
    e_valid = (exp_q.size() != 0);
    e_stall = (exp_q.size() == DEPTH);
    total++;
    assert (cdb_valid === e_valid) else begin
      bad++;
      $error("FAIL %s cdb_valid observed=%0b expected=%0b", tag, cdb_valid, e_valid);
    end
    total++;
    assert (wb_stall === e_stall) else begin
      bad++;
      $error("FAIL %s wb_stall observed=%0b expected=%0b", tag, wb_stall, e_stall);
    end
    if (e_valid) begin
      head = exp_q[0];
      total++;
      assert (cdb_tag === head[DATA_W +: TAG_W]) else begin
        bad++;
        $error("FAIL %s cdb_tag observed=%0d expected=%0d", tag, cdb_tag, head[DATA_W +: TAG_W]);
      end
      total++;
      assert (cdb_data === head[DATA_W-1:0]) else begin
        bad++;
        $error("FAIL %s cdb_data observed=%h expected=%h", tag, cdb_data, head[DATA_W-1:0]);
      end
    end else if (fresh_reset) begin
      total++;
      assert ({cdb_tag, cdb_data} === '0) else begin
        bad++;
        $error("FAIL %s reset_tag_data observed=%h/%h expected=0/0", tag, cdb_tag, cdb_data);
      end
    end
  endtask

  // One clock: drive inputs at the falling edge, advance the model at the rising edge,
  // then check outputs at the next falling edge.
  task automatic cycle(input string tag, input logic r, input logic av, input logic [TAG_W-1:0] at,
                       input logic [DATA_W-1:0] ad, input logic lv, input logic [TAG_W-1:0] lt,
                       input logic [DATA_W-1:0] ld, input logic sel, input logic fl, input logic rr);
    logic                    s_valid;
    logic [TAG_W+DATA_W-1:0] s_rec;
    bit                      was_full;
    rst = r; alu_valid = av; alu_tag = at; alu_data = ad;
    ls_valid = lv; ls_tag = lt; ls_data = ld;
    sel_result = sel; flush = fl; rob_ready = rr;
    s_valid  = sel ? lv : av;
    s_rec    = sel ? {lt, ld} : {at, ad};
    was_full = (exp_q.size() == DEPTH);
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      fresh_reset = 1'b1;
    end else if (fl) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && rr) void'(exp_q.pop_front());
      if (s_valid && !was_full) begin
        exp_q.push_back(s_rec);
        fresh_reset = 1'b0;
      end
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic alu_push(input string tag, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d,
                          input logic rr);
    cycle(tag, 1'b0, 1'b1, t, d, 1'b0, '0, '0, 1'b0, 1'b0, rr);
  endtask

  task automatic idle(input string tag, input logic rr);
    cycle(tag, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, rr);
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_tag = '0; alu_data = '0;
    ls_valid = 1'b0; ls_tag = '0; ls_data = '0;
    sel_result = 1'b0; flush = 1'b0; rob_ready = 1'b0;
    @(negedge clk);

    // Reset held two cycles with an ALU result offered, then one idle cycle.
    cycle("reset0", 1'b1, 1'b1, 6'd4, 32'h1234, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cycle("reset1", 1'b1, 1'b1, 6'd4, 32'h1234, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle("reset_rel", 1'b1);

    // Single ALU result.
    alu_push("single", 6'd5, 32'hDEADBEEF, 1'b1);
    idle("single_drain", 1'b1);

    // Back-pressure: ROB not ready while two results are offered.
    alu_push("bp_push1", 6'd1, 32'h11, 1'b0);
    alu_push("bp_push2", 6'd2, 32'h22, 1'b0);
    idle("bp_hold", 1'b0);
    idle("bp_drain1", 1'b1);
    idle("bp_drain2", 1'b1);
    idle("bp_drain3", 1'b1);

    // Source select: both offered, load/store granted.
    cycle("srcsel", 1'b0, 1'b1, 6'd3, 32'h33, 1'b1, 6'd9, 32'h99, 1'b1, 1'b0, 1'b1);
    idle("srcsel_drain", 1'b1);

    // Flush with a full queue and a concurrent push.
    alu_push("fl_fill1", 6'd11, 32'hAA, 1'b0);
    alu_push("fl_fill2", 6'd12, 32'hBB, 1'b0);
    cycle("flush", 1'b0, 1'b1, 6'd7, 32'h77, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    idle("flush_after1", 1'b1);
    idle("flush_after2", 1'b1);

    // Continuous ALU pushes with the ROB always ready.
    for (int i = 0; i < 8; i++) alu_push("stream", TAG_W'(20 + i), 32'hC000 + i, 1'b1);
    idle("stream_drain", 1'b1);

    // Reset in the middle of held results.
    alu_push("mid_fill1", 6'd30, 32'h300, 1'b0);
    alu_push("mid_fill2", 6'd31, 32'h310, 1'b0);
    cycle("mid_reset", 1'b1, 1'b1, 6'd32, 32'h320, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    idle("mid_after", 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("random",
            ($urandom_range(0, 63) == 0),
            1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 63)), $urandom,
            1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 63)), $urandom,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_writeback.md
CDB_WRITEBACK -- requirements
Module: cdb_writeback

Interface
REQ-001 Parameter DATA_W, default 32, result data width.
REQ-002 Parameter TAG_W, default 6, ROB tag width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 alu_valid  input  1  ALU result present.
REQ-006 alu_tag  input  TAG_W  ALU result ROB tag.
REQ-007 alu_data  input  DATA_W  ALU result value.
REQ-008 ls_valid  input  1  load/store result present.
REQ-009 ls_tag  input  TAG_W  load/store result ROB tag.
REQ-010 ls_data  input  DATA_W  load/store result value.
REQ-011 sel_result  input  1  arbiter grant; 0 = ALU, 1 = load/store.
REQ-012 flush  input  1  pipeline flush; discards all held results.
REQ-013 rob_ready  input  1  ROB/reservation stations accept the broadcast this cycle.
REQ-014 cdb_valid  output  1  broadcast valid.
REQ-015 cdb_tag  output  TAG_W  broadcast ROB tag.
REQ-016 cdb_data  output  DATA_W  broadcast value.
REQ-017 wb_stall  output  1  back-pressure to arbiter; asserted means no capture this cycle.

Function
REQ-018 Selected source: sel_result=0 picks alu_*, sel_result=1 picks ls_*; the unselected source is ignored.
REQ-019 Push occurs when selected valid=1, wb_stall=0, flush=0.
REQ-020 Pop occurs when cdb_valid=1 and rob_ready=1.
REQ-021 Results are held in an in-order queue of DEPTH entries; cdb_* always present the oldest entry, all outputs driven from registers.
REQ-022 Latency: a result pushed in cycle N appears on cdb_* in cycle N+1 if the queue was empty or popped empty in cycle N.
REQ-023 cdb_valid, cdb_tag, cdb_data remain stable while cdb_valid=1 and rob_ready=0.
REQ-024 wb_stall = (occupancy == DEPTH), registered-equivalent; it does not depend combinationally on rob_ready or any input.
REQ-025 Simultaneous push and pop when not full: occupancy unchanged, order preserved.
REQ-026 Push attempted while full is dropped by the upstream contract; block does not capture and does not flag an error.
REQ-027 Pointers wrap modulo DEPTH; occupancy counter is ceil(log2(DEPTH+1)) bits and never exceeds DEPTH.
REQ-028 flush=1: next cycle occupancy=0, cdb_valid=0, wb_stall=0; a same-cycle push is discarded.

Reset
REQ-029 rst=1 on a rising edge: next cycle cdb_valid=0, cdb_tag=0, cdb_data=0, wb_stall=0, pointers and occupancy=0.
REQ-030 rst asserted mid-operation discards all held results; rst has priority over flush, push and pop.

Configuration
REQ-031 Macro CDB_FIFO_EN defined: DEPTH=2; wb_stall asserts only when both entries are occupied.
REQ-032 Macro CDB_FIFO_EN undefined: DEPTH=1, a single output register; wb_stall=1 whenever cdb_valid=1, so back-to-back results incur one bubble cycle.

Structure
REQ-033 DATA_W/TAG_W defaults, the source-select encoding (SEL_ALU=0, SEL_LS=1) and a result-record typedef (valid, tag, data) reside in the shared OoO pipeline package.
REQ-034 Queue storage and pointers form a sub-module, cdb_fifo, parameterised by DEPTH; cdb_writeback contains source mux, push/pop control and stall generation.

Verification
REQ-035 Reset: rst=1 for 2 cycles with alu_valid=1 -> cdb_valid=0, wb_stall=0 throughout and one cycle after release.
REQ-036 Single ALU result: sel_result=0, alu_valid=1, alu_tag=5, alu_data=0xDEADBEEF, rob_ready=1 -> next cycle cdb_valid=1, tag 5, data 0xDEADBEEF; following cycle cdb_valid=0.
REQ-037 Back-pressure: rob_ready=0, push tags 1, 2 -> (CDB_FIFO_EN) wb_stall=1 after second push, cdb_tag=1 stable; rob_ready=1 -> tag 1 then tag 2 broadcast in order.
REQ-038 Source select: alu_valid=1 tag 3, ls_valid=1 tag 9, sel_result=1 -> broadcast tag 9 only; tag 3 never appears.
REQ-039 Flush: queue holding two entries, flush=1 with concurrent push tag 7 -> next cycle cdb_valid=0, wb_stall=0; tag 7 never broadcast.
REQ-040 Build without CDB_FIFO_EN: continuous ALU pushes every cycle, rob_ready=1 -> wb_stall alternates 0/1, results broadcast every second cycle.
